// File: rtl/ps2_tx_if.sv
// ps2_tx_if: host-side command handshake of the PS/2 transmitter.
//   wr_ps2       - one-cycle start strobe (taken only while tx_idle=1)
//   din          - command byte to send
//   tx_idle      - no transfer in progress
//   tx_done_tick - one-cycle pulse when a transfer ends (good or failed)
//   ack_err      - device did not ACK; valid with tx_done_tick
//   timeout_err  - device clock stalled; valid with tx_done_tick
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       timeout_err;

    modport master (output wr_ps2, din,
                    input  tx_idle, tx_done_tick, ack_err, timeout_err);
    modport slave  (input  wr_ps2, din,
                    output tx_idle, tx_done_tick, ack_err, timeout_err);
endinterface

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter.
//   clk   - system clock, all logic on its rising edge
//   reset - synchronous, active-low
//   bus   - command handshake (ps2_tx_if.slave)
//   ps2c  - PS/2 clock, open-drain (drives 0 or Z)
//   ps2d  - PS/2 data, open-drain (drives 0 or Z)
// The host pulls the clock low for RTS_CYCLES (request-to-send), then the
// device clocks out start, d0..d7, odd parity and stop, and ACKs by pulling
// data low. A stalled device clock aborts the transfer after TIMEOUT_CYCLES.
module ps2_tx #(
    parameter int RTS_CYCLES     = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic    clk,
    input  logic    reset,
    ps2_tx_if.slave bus,
    inout  wire     ps2c,
    inout  wire     ps2d
);
    localparam int MAXC = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL} state_e;

    // ---------------- input conditioning ----------------
    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  filtc_q, filtc_d;
    logic                  fall_edge, d_in;

    assign filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};

    // Filtered clock only moves when every tap agrees, so short glitches
    // never reach the edge detector.
    always_comb begin
        filtc_d = filtc_q;
        if (&filt_q)       filtc_d = 1'b1;
        else if (~|filt_q) filtc_d = 1'b0;
    end

    assign fall_edge = filtc_q & ~filtc_d;
    assign d_in      = d_sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            filt_q   <= '1;
            filtc_q  <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
            filt_q   <= filt_d;
            filtc_q  <= filtc_d;
        end
    end

    // ---------------- transfer FSM ----------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    nbit_q, nbit_d;
    logic          ack_err_q, ack_err_d;
    logic          tout_err_q, tout_err_d;
    logic          done_q, done_d;
    logic          c_drv, d_drv;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '1;
            nbit_q     <= '0;
            ack_err_q  <= 1'b0;
            tout_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            nbit_q     <= nbit_d;
            ack_err_q  <= ack_err_d;
            tout_err_q <= tout_err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        nbit_d     = nbit_q;
        ack_err_d  = ack_err_q;
        tout_err_d = tout_err_q;
        done_d     = 1'b0;
        c_drv      = 1'b0;
        d_drv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wr_ps2) begin
                    shift_d    = {~^bus.din, bus.din};
                    cnt_d      = '0;
                    ack_err_d  = 1'b0;
                    tout_err_d = 1'b0;
                    state_d    = RTS;
                end
            end
            RTS: begin
                c_drv = 1'b1;
                // data goes low slightly before the clock is released
                d_drv = (cnt_q >= CW'(RTS_CYCLES - 2));
                if (cnt_q == CW'(RTS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                d_drv = 1'b1;
                if (fall_edge) begin
                    nbit_d  = 4'd8;
                    state_d = DATA;
                end
            end
            DATA: begin
                d_drv = ~shift_q[0];
                if (fall_edge) begin
                    if (nbit_q == 4'd0) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b1, shift_q[8:1]};
                        nbit_d  = nbit_q - 4'd1;
                    end
                end
            end
            STOP: begin
                if (fall_edge) state_d = ACK;
            end
            ACK: begin
                if (fall_edge) begin
                    ack_err_d = d_in;
                    state_d   = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (filtc_q && d_in) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Device-clock watchdog: restarted by every falling edge, overrides
        // any transition above when it expires.
        if (state_q inside {START, DATA, STOP, ACK, WAIT_REL}) begin
            if (fall_edge) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                cnt_d      = '0;
                tout_err_d = 1'b1;
                done_d     = 1'b1;
                state_d    = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign ps2c = c_drv ? 1'b0 : 1'bz;
    assign ps2d = d_drv ? 1'b0 : 1'bz;

    assign bus.tx_idle      = (state_q == IDLE);
    assign bus.tx_done_tick = done_q;
    assign bus.ack_err      = ack_err_q;
    assign bus.timeout_err  = tout_err_q;
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: random and directed transfers against a PS/2 device model that
// clocks the frame, samples data on its rising edges and optionally ACKs.
// A per-cycle compare process tracks busy/idle and the request-to-send
// window from the acceptance cycle alone.
module tb_ps2_tx;
    localparam int RTS = 50;
    localparam int TO  = 1000;
    localparam int FL  = 8;
    localparam int HP  = 30;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_tx_if bus();
    wire  ps2c, ps2d;
    logic dev_c = 1'b0, dev_d = 1'b0;
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset(reset), .bus(bus), .ps2c(ps2c), .ps2d(ps2d));

    int total = 0, bad = 0;
    int cyc = 0;
    int n_done = 0;
    int dev_bit = 0;
    bit m_busy = 1'b0;
    int m_acc = -100000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    // per-cycle compare against the busy/idle model
    int k;
    always @(negedge clk) begin
        if (bus.tx_done_tick) begin
            chk("done_while_busy", m_busy, 1);
            chk("idle_with_done", bus.tx_idle, 1);
            n_done++;
            m_busy = 1'b0;
        end
        chk("tx_idle", bus.tx_idle, !m_busy);
        if (bus.tx_idle) begin
            chk("idle_c_rel", ps2c === 1'b1, !dev_c);
            chk("idle_d_rel", ps2d === 1'b1, !dev_d);
        end
        if (m_busy) begin
            k = cyc - m_acc;
            if (k >= 1 && k <= RTS)     chk("rts_c_low", ps2c === 1'b0, 1);
            if (k == RTS + 1)           chk("start_c_rel", ps2c === 1'b1, 1);
            if (k >= RTS - 1 && k <= RTS + 1) chk("rts_d_low", ps2d === 1'b0, 1);
            if (k >= 1 && k < RTS - 1)  chk("rts_d_high", ps2d === 1'b1, 1);
        end
        if (!reset) m_busy = 1'b0;
        else if (bus.wr_ps2 && !m_busy) begin
            m_busy = 1'b1;
            m_acc  = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] d, output int acc);
        acc = cyc;
        bus.din = d;
        bus.wr_ps2 = 1'b1;
        tick(1);
        bus.wr_ps2 = 1'b0;
    endtask

    task automatic dev_xfer(input bit do_ack, input bit glitch, output logic [7:0] rx,
                            output logic par, output logic stp, output bit ok);
        int t;
        ok = 1'b0; rx = '0; par = 1'b0; stp = 1'b0;
        t = 0;
        while (ps2c !== 1'b0 && t < 5000) begin tick(1); t++; end
        if (t >= 5000) return;
        t = 0;
        while (!(ps2c === 1'b1 && ps2d === 1'b0) && t < 5000) begin tick(1); t++; end
        if (t >= 5000) return;
        tick(20);
        for (int b = 1; b <= 12; b++) begin
            dev_bit = b;
            dev_c = 1'b1;
            tick(HP);
            dev_c = 1'b0;
            if (b <= 8) rx[b-1] = (ps2d === 1'b1);
            else if (b == 9) par = (ps2d === 1'b1);
            else if (b == 10) begin
                stp = (ps2d === 1'b1);
                dev_d = do_ack;
            end else if (b == 12) dev_d = 1'b0;
            if (glitch && b >= 2 && b <= 8) begin
                tick(10); dev_c = 1'b1; tick(3); dev_c = 1'b0; tick(HP - 13);
            end else begin
                tick(HP);
            end
        end
        dev_bit = 0;
        ok = 1'b1;
    endtask

    // inj: 0 none, 1 wr_ps2 of 0x00 during bit 4
    task automatic xfer(input string nm, input logic [7:0] d, input bit ack, input bit glitch,
                        input logic exp_par, input int inj);
        logic [7:0] rx;
        logic par, stp;
        bit ok;
        int acc, acc2, n0, t;
        n0 = n_done;
        send(d, acc);
        fork
            dev_xfer(ack, glitch, rx, par, stp, ok);
            begin
                if (inj == 1) begin
                    t = 0;
                    while (dev_bit != 5 && t < 5000) begin tick(1); t++; end
                    tick(5);
                    send(8'h00, acc2);
                end
            end
        join
        tick(20);
        chk({nm, "_dev_ok"}, ok, 1);
        chk({nm, "_rx"}, rx, d);
        chk({nm, "_par"}, par, exp_par);
        chk({nm, "_stop"}, stp, 1);
        chk({nm, "_ndone"}, n_done, n0 + 1);
        chk({nm, "_ack_err"}, bus.ack_err, !ack);
        chk({nm, "_to_err"}, bus.timeout_err, 0);
        chk({nm, "_idle"}, bus.tx_idle, 1);
    endtask

    initial begin : main
        logic [7:0] rx, d;
        logic par, stp;
        bit ok;
        int acc, n0, t, a;
        bus.wr_ps2 = 1'b0;
        bus.din = 8'h00;
        reset = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_idle", bus.tx_idle, 1);
        chk("rst_done", bus.tx_done_tick, 0);
        chk("rst_ack_err", bus.ack_err, 0);
        chk("rst_to_err", bus.timeout_err, 0);
        chk("rst_c", ps2c === 1'b1, 1);
        chk("rst_d", ps2d === 1'b1, 1);
        tick(1);
        reset = 1'b1;
        tick(5);

        xfer("f4", 8'hF4, 1'b1, 1'b0, 1'b0, 0);
        xfer("ff_noack", 8'hFF, 1'b0, 1'b0, 1'b1, 0);

        // device never clocks: watchdog ends the transfer
        n0 = n_done;
        send(8'h5A, acc);
        t = 0;
        while (t < RTS + TO + 200) begin
            @(negedge clk);
            if (bus.tx_done_tick) break;
            t++;
        end
        chk("to_seen", bus.tx_done_tick, 1);
        chk("to_latency", cyc - acc, RTS + 1 + TO);
        chk("to_err", bus.timeout_err, 1);
        chk("to_ack_err", bus.ack_err, 0);
        chk("to_c_rel", ps2c === 1'b1, 1);
        chk("to_d_rel", ps2d === 1'b1, 1);
        tick(10);
        chk("to_ndone", n_done, n0 + 1);

        d = 8'($urandom);
        xfer("glitch", d, 1'b1, 1'b1, odd_par(d), 0);
        xfer("ignored_wr", 8'hED, 1'b1, 1'b0, 1'b1, 1);

        // reset during bit 4
        n0 = n_done;
        send(8'hA5, acc);
        fork
            dev_xfer(1'b1, 1'b0, rx, par, stp, ok);
            begin
                t = 0;
                while (dev_bit != 5 && t < 5000) begin tick(1); t++; end
                tick(5);
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
                chk("midrst_idle", bus.tx_idle, 1);
                chk("midrst_ack_err", bus.ack_err, 0);
                chk("midrst_to_err", bus.timeout_err, 0);
            end
        join
        tick(20);
        chk("midrst_no_done", n_done, n0);
        xfer("after_rst", 8'hF4, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            a = $urandom_range(0, 3);
            xfer("rand", d, a != 0, 1'($urandom_range(0, 1)), odd_par(d), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
